// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the set-associative data cache.
package dcache_pkg;

  localparam int OFFSET_W = 2;
  localparam int TAG_MAX  = 32;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } dcache_state_t;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TAG_MAX-1:0] tag;
  } line_meta_t;

  function automatic int word_bits(input int block_words);
    return $clog2(block_words);
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_width, input int sets, input int block_words);
    return addr_width - OFFSET_W - word_bits(block_words) - index_bits(sets);
  endfunction

  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[b*8 +: 8] = be[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set age-based LRU: victim is the lowest invalid way, otherwise the oldest way.
module dcache_lru
  import dcache_pkg::*;
#(
  parameter int SETS = 16,
  parameter int WAYS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [index_bits(SETS)-1:0]  set_idx,
  input  logic [WAYS-1:0]              valid,
  input  logic                         access,
  input  logic [way_bits(WAYS)-1:0]    access_way,
  output logic [way_bits(WAYS)-1:0]    victim_way
);

  localparam int WAY_W = way_bits(WAYS);

  generate
    if (WAYS == 1) begin : g_direct
      logic unused_s;
      assign unused_s   = clk ^ rst_n ^ (^set_idx) ^ (^valid) ^ access ^ (^access_way);
      assign victim_way = {WAY_W{1'b0}};
    end else begin : g_assoc
      logic [WAY_W-1:0] age_r [SETS][WAYS];
      logic [WAY_W-1:0] old_age_s;
      logic [WAY_W-1:0] inv_way_s;
      logic [WAY_W-1:0] old_way_s;
      logic             any_inv_s;

      assign old_age_s = age_r[set_idx][access_way];

      // ages reset to the way number; accessed way becomes youngest
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
              age_r[s][w] <= WAY_W'(w);
            end
          end
        end else if (access) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == access_way) begin
              age_r[set_idx][w] <= {WAY_W{1'b0}};
            end else if (age_r[set_idx][w] < old_age_s) begin
              age_r[set_idx][w] <= age_r[set_idx][w] + WAY_W'(1);
            end
          end
        end
      end

      // descending scan so the lowest-numbered match wins
      always_comb begin
        inv_way_s = {WAY_W{1'b0}};
        old_way_s = {WAY_W{1'b0}};
        any_inv_s = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
          inv_way_s = !valid[w] ? WAY_W'(w) : inv_way_s;
          any_inv_s = any_inv_s | !valid[w];
          old_way_s = (age_r[set_idx][w] == WAY_W'(WAYS - 1)) ? WAY_W'(w) : old_way_s;
        end
        victim_way = any_inv_s ? inv_way_s : old_way_s;
      end
    end
  endgenerate

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-back/write-allocate data cache with a word-serial
// writeback/refill handshake to backing memory and hit/miss counters.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SETS        = 16,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
);

  localparam int WORD_W = word_bits(BLOCK_WORDS);
  localparam int IDX_W  = index_bits(SETS);
  localparam int TAG_W  = tag_bits(ADDR_WIDTH, SETS, BLOCK_WORDS);
  localparam int WAY_W  = way_bits(WAYS);

  dcache_state_t         state_r, state_n;
  logic [WORD_W-1:0]     word_s, cnt_r;
  logic [IDX_W-1:0]      idx_s;
  logic [TAG_W-1:0]      tag_s, wb_tag_r;
  logic [WAY_W-1:0]      hit_way_s, victim_s, victim_r;
  logic [WAYS-1:0]       valid_vec_s;
  logic                  hit_s, hit_ev_s, miss_ev_s, last_s, refill_done_s, unused_s;
  logic [31:0]           hit_count_r, miss_count_r;
  line_meta_t            meta_r [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_r [SETS][WAYS][BLOCK_WORDS];

  assign word_s        = addr_i[OFFSET_W +: WORD_W];
  assign idx_s         = addr_i[OFFSET_W + WORD_W +: IDX_W];
  assign tag_s         = addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign unused_s      = ^addr_i[OFFSET_W-1:0];
  assign last_s        = (cnt_r == WORD_W'(BLOCK_WORDS - 1));
  assign refill_done_s = (state_r == S_REFILL) && mem_ack_i && last_s;
  assign hit_count_o   = hit_count_r;
  assign miss_count_o  = miss_count_r;

  // tag lookup across all ways of the indexed set
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = {WAY_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      valid_vec_s[w] = meta_r[idx_s][w].valid;
      if (meta_r[idx_s][w].valid && (meta_r[idx_s][w].tag == TAG_MAX'(tag_s))) begin
        hit_s     = 1'b1;
        hit_way_s = WAY_W'(w);
      end else begin
        hit_s     = hit_s;
      end
    end
    if (hit_s) begin
      rdata_o = data_r[idx_s][hit_way_s][word_s];
    end else begin
      rdata_o = {DATA_WIDTH{1'b0}};
    end
  end

  dcache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .set_idx    (idx_s),
    .valid      (valid_vec_s),
    .access     (hit_ev_s),
    .access_way (hit_way_s),
    .victim_way (victim_s)
  );

  // next state and memory handshake outputs
  always_comb begin
    state_n     = state_r;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {ADDR_WIDTH{1'b0}};
    mem_wdata_o = {DATA_WIDTH{1'b0}};
    hit_ev_s    = 1'b0;
    miss_ev_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_i && hit_s) begin
          hit_ev_s = 1'b1;
        end else if (req_i) begin
          stall_o   = 1'b1;
          miss_ev_s = 1'b1;
          state_n   = (meta_r[idx_s][victim_s].valid && meta_r[idx_s][victim_s].dirty)
                      ? S_WRITEBACK : S_REFILL;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {wb_tag_r, idx_s, cnt_r, 2'b00};
        mem_wdata_o = data_r[idx_s][victim_r][cnt_r];
        if (mem_ack_i && last_s) begin
          state_n = S_REFILL;
        end else begin
          state_n = S_WRITEBACK;
        end
      end
      S_REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {tag_s, idx_s, cnt_r, 2'b00};
        if (mem_ack_i && last_s) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_REFILL;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // FSM, word counter (wraps to 0 after the last word) and latched victim
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= S_IDLE;
      cnt_r    <= {WORD_W{1'b0}};
      victim_r <= {WAY_W{1'b0}};
      wb_tag_r <= {TAG_W{1'b0}};
    end else begin
      state_r <= state_n;
      if (mem_req_o && mem_ack_i) begin
        cnt_r <= cnt_r + WORD_W'(1);
      end
      if (miss_ev_s) begin
        victim_r <= victim_s;
        wb_tag_r <= TAG_W'(meta_r[idx_s][victim_s].tag);
      end
    end
  end

  // line metadata: refill installs a clean line, a store hit marks it dirty
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          meta_r[s][w] <= '{valid: 1'b0, dirty: 1'b0, tag: {TAG_MAX{1'b0}}};
        end
      end
    end else if (refill_done_s) begin
      meta_r[idx_s][victim_r] <= '{valid: 1'b1, dirty: 1'b0, tag: TAG_MAX'(tag_s)};
    end else if (hit_ev_s && we_i) begin
      meta_r[idx_s][hit_way_s].dirty <= 1'b1;
    end
  end

  // data array carries no reset; contents are qualified by the valid bits
  always_ff @(posedge clk_i) begin
    if ((state_r == S_REFILL) && mem_ack_i) begin
      data_r[idx_s][victim_r][cnt_r] <= mem_rdata_i;
    end else if (hit_ev_s && we_i) begin
      data_r[idx_s][hit_way_s][word_s] <=
        merge_bytes(data_r[idx_s][hit_way_s][word_s], wdata_i, be_i);
    end
  end

  // saturating performance counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      if (hit_ev_s && (hit_count_r != 32'hFFFF_FFFF)) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
      if (miss_ev_s && (miss_count_r != 32'hFFFF_FFFF)) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Parametrised set-associative, write-back, write-allocate data cache for the memory stage of the pipelined core. It replaces the fixed single-cycle cache with one configurable in sets, ways and block size. Misses go through a multi-cycle word-serial handshake to the backing data memory, and `stall_o` drives the hazard unit's stall inputs. It also carries per-set LRU replacement and hit/miss performance counters.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width
- `DATA_WIDTH`, 32, word width; fixed at 32 (4 byte lanes)
- `SETS`, 16, number of sets; power of 2, at least 2
- `WAYS`, 2, associativity; one of 1, 2 or 4
- `BLOCK_WORDS`, 4, words per line; power of 2, at least 2

Ports:
- `clk_i`  in  1  sole clock, rising edge
- `rst_i`  in  1  asynchronous, active-low reset
- `req_i`  in  1  CPU access valid (load or store in M stage)
- `we_i`  in  1  store when 1, load when 0
- `be_i`  in  4  store byte enables
- `addr_i`  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- `wdata_i`  in  32  store data
- `rdata_o`  out  32  load data, valid when `req_i && !we_i && !stall_o`
- `stall_o`  out  1  access not complete; CPU holds all request inputs stable
- `mem_req_o`  out  1  memory transfer request
- `mem_we_o`  out  1  1 = writeback word, 0 = refill word
- `mem_addr_o`  out  ADDR_WIDTH  word-aligned memory address
- `mem_wdata_o`  out  32  writeback data
- `mem_ack_i`  in  1  memory accepted or returned the current word
- `mem_rdata_i`  in  32  refill data, valid with `mem_ack_i`
- `hit_count_o`  out  32  saturating count of completed hits
- `miss_count_o`  out  32  saturating count of misses

## Operation
- Address split: offset [1:0]; word = next log2(BLOCK_WORDS) bits; index = next log2(SETS) bits; tag = the rest.
- Per line state: valid bit, dirty bit, tag, BLOCK_WORDS data words. Per set: one LRU age field per way.
- FSM states are IDLE, WRITEBACK, REFILL.
- IDLE, request hits:
  - Load data is returned combinationally.
  - A store updates the selected bytes at the clock edge and sets dirty.
  - The hit way's LRU age is updated.
  - `stall_o` = 0.
- IDLE, request misses: `stall_o` = 1 and `miss_count_o` increments once. Victim is the lowest-numbered invalid way, otherwise the LRU way. Next state is WRITEBACK if the victim is valid and dirty, else REFILL.
- WRITEBACK: sends BLOCK_WORDS words, word 0 first, to the victim's old address, then goes to REFILL.
- REFILL: fetches BLOCK_WORDS words of the requested block, word 0 first. On the last ack the line is written as valid=1, dirty=0 with the new tag, and the FSM returns to IDLE. There the access replays as a hit, which counts in `hit_count_o`.
- LRU: an accessed way gets age 0; ways younger than its old age increment. The way with the maximum age is LRU. With WAYS=1 there is no LRU field and the victim is always way 0.
- `stall_o` is high in WRITEBACK and REFILL, and combinationally high in IDLE on a miss.

## Timing
- Memory handshake:
  - `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are held stable until `mem_ack_i` is sampled high.
  - After an ack, the next word's request is presented the following cycle with no idle gap.
  - `mem_ack_i` while `mem_req_o` = 0 is ignored.
- Hit latency is 0 extra cycles.
- Clean-miss latency: (BLOCK_WORDS refill acks) + 1 replay cycle. A dirty miss adds BLOCK_WORDS writeback acks.
- Reset values:
  - All valid and dirty bits 0, LRU ages equal to the way number, FSM in IDLE.
  - `stall_o` 0, `mem_req_o` 0, `mem_we_o` 0, `mem_addr_o` 0, `mem_wdata_o` 0.
  - Both counters 0.
- Reset asserted mid-miss aborts the transfer immediately. Dirty data is lost by design.
- `req_i` = 0 in IDLE: no state change and no counter change.
- Counters saturate at 0xFFFF_FFFF.

## Structure
- Package `dcache_pkg` holds:
  - the state enum `dcache_state_t`;
  - the localparam helpers for offset, word, index and tag widths;
  - the line-metadata struct (valid, dirty, tag).
- Sub-module `dcache_lru`: per-set age storage, victim selection (first invalid, else oldest) and age update on access.

## Test plan
- Reset, then load 0x100 with memory words 0xA0..0xA3: exactly 4 refill handshakes at 0x100–0x10C, `stall_o` high for 5 cycles, `rdata_o` = 0xA0, miss=1, hit=1.
- Store 0xDEADBEEF with `be_i` = 4'b0011 to 0x104 after that refill: no stall; a subsequent load of 0x104 returns 0xA1 with bytes [15:0] = 0xBEEF.
- WAYS=2, SETS=16, BLOCK_WORDS=4: access 0x000, 0x400, 0x000, then 0x800. Victim is the 0x400 line, and reloading 0x000 hits.
- Dirty victim eviction: 4 writeback words with `mem_we_o` = 1 at the old tag address precede 4 refill reads.
- `mem_ack_i` delayed 3 cycles per word: request signals stay stable, and total stall equals the sum of the wait cycles plus 1.
- Assert `rst_i` low during the REFILL of word 2: outputs return to their reset values at once, and a reload of the same address is a miss again.
